// File: rtl/mux_pkg.sv
// Shared constants and types for the MUX board interrupt controller.
package mux_pkg;

    // CPU register window indices.
    localparam logic [4:0] ADDR_ENABLE     = 5'd0;
    localparam logic [4:0] ADDR_LEVEL      = 5'd1;
    localparam logic [4:0] ADDR_CAUSE      = 5'd2;
    localparam logic [4:0] ADDR_PENDING    = 5'd3;
    localparam logic [4:0] ADDR_GLOBAL_OFF = 5'd13;
    localparam logic [4:0] ADDR_GLOBAL_ON  = 5'd14;
    localparam logic [4:0] ADDR_CLEAR_ALL  = 5'd15;

    // Cause register layout: {valid, 4'b0, type, ch[1:0]}.
    localparam int CAUSE_VALID_BIT = 7;
    localparam int CAUSE_TYPE_BIT  = 2;
    localparam int CAUSE_CH_LSB    = 0;
    localparam int CAUSE_CH_WIDTH  = 2;

    // Enable/pending byte layout: rx channels in the low nibble, tx in the high nibble.
    localparam int TX_BYTE_OFFSET = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_REQUEST = 2'd2,
        ST_SERVICE = 2'd3
    } mux_state_e;

    // Interrupt level after reset or a clear-all write.
    localparam logic [7:0] LEVEL_RESET = 8'h00;

endpackage

// File: rtl/mux_rr_picker.sv
// Combinational round-robin first-one finder: returns the first set bit of
// req found by walking upward from start and wrapping modulo WIDTH.
module mux_rr_picker
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] probe;

    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        found = 1'b0;
        index = '0;
        probe = '0;
        for (int off = WIDTH - 1; off >= 0; off--) begin
            probe = IDX_W'((int'(start) + off) % WIDTH);
            if (req[probe]) begin
                found = 1'b1;
                index = probe;
            end
        end
    end

endmodule

// File: rtl/mux_int_arbiter.sv
// Interrupt controller for the serial multiplexer board. Latches rx-ready and
// tx-idle edges from the UART channels as pending sources, grants one enabled
// source round-robin, raises int_reqn until the CPU acknowledges, and exposes
// the cause through a small register window.
//
// Handshake: int_reqn is held low with irq_number valid for as long as the FSM
// is in REQUEST; the CPU accepts by pulsing int_ack for one cycle, which is
// honoured only while the request is up and the granted source is still
// eligible. The CPU then reads the cause register to retire the source.
module mux_int_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int LEVEL_WIDTH  = 4
) (
    input  logic                    cpu_clock,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] rx_ready,
    input  logic [NUM_CHANNELS-1:0] tx_idle,
    input  logic                    selected,
    input  logic [4:0]              address,
    input  logic                    write_en,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    input  logic                    int_ack,
    output logic                    int_reqn,
    output logic [LEVEL_WIDTH-1:0]  irq_number,
    output mux_state_e              fsm_state
);

    localparam int NUM_SOURCES = 2 * NUM_CHANNELS;
    localparam int IDX_W       = $clog2(NUM_SOURCES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SOURCES - 1);

    mux_state_e state, state_next;

    // Source vectors use k = 2*ch + type (type 0 = rx, 1 = tx).
    logic [NUM_SOURCES-1:0] src_level, src_prev, rise;
    logic [NUM_SOURCES-1:0] pending, enable, eligible;
    logic [NUM_SOURCES-1:0] wr_vec, clear_vec, served_vec;
    logic [7:0]             enable_byte, pending_byte, cause_byte, read_byte;
    logic [LEVEL_WIDTH-1:0] level;
    logic                   global_en, valid;
    logic [IDX_W-1:0]       grant, last_grant, start_idx, pick_index;
    logic                   pick_found;

    logic cpu_read, cpu_write;
    logic wr_enable, wr_level, wr_pending, wr_global_off, wr_global_on, wr_clear_all;
    logic cause_hit, granted_w1c;
    logic load_grant, set_valid, clr_valid;

    assign cpu_read      = selected && !write_en;
    assign cpu_write     = selected && write_en;
    assign wr_enable     = cpu_write && (address == ADDR_ENABLE);
    assign wr_level      = cpu_write && (address == ADDR_LEVEL);
    assign wr_pending    = cpu_write && (address == ADDR_PENDING);
    assign wr_global_off = cpu_write && (address == ADDR_GLOBAL_OFF);
    assign wr_global_on  = cpu_write && (address == ADDR_GLOBAL_ON);
    assign wr_clear_all  = cpu_write && (address == ADDR_CLEAR_ALL);

    assign rise        = src_level & ~src_prev;
    assign eligible    = pending & enable & {NUM_SOURCES{global_en}};
    assign cause_hit   = cpu_read && (address == ADDR_CAUSE) && valid;
    assign granted_w1c = wr_pending && wr_vec[grant];
    assign clear_vec   = (wr_pending ? wr_vec : '0) | served_vec;
    assign start_idx   = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
    assign fsm_state   = state;

    // Translate between the k-indexed source order and the rx-low/tx-high byte layout.
    always_comb begin
        src_level    = '0;
        wr_vec       = '0;
        enable_byte  = '0;
        pending_byte = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            src_level[2*ch]                   = rx_ready[ch];
            src_level[2*ch+1]                 = tx_idle[ch];
            wr_vec[2*ch]                      = data_in[ch];
            wr_vec[2*ch+1]                    = data_in[TX_BYTE_OFFSET+ch];
            enable_byte[ch]                   = enable[2*ch];
            enable_byte[TX_BYTE_OFFSET+ch]    = enable[2*ch+1];
            pending_byte[ch]                  = pending[2*ch];
            pending_byte[TX_BYTE_OFFSET+ch]   = pending[2*ch+1];
        end
    end

    // One-hot of the granted source, asserted when a cause read retires it.
    always_comb begin
        served_vec        = '0;
        served_vec[grant] = cause_hit;
    end

    // Cause register contents; reads as zero whenever no cause is held.
    always_comb begin
        cause_byte = '0;
        if (valid) begin
            cause_byte[CAUSE_VALID_BIT]                      = 1'b1;
            cause_byte[CAUSE_TYPE_BIT]                       = grant[0];
            cause_byte[CAUSE_CH_LSB +: CAUSE_CH_WIDTH]       = CAUSE_CH_WIDTH'(grant >> 1);
        end
    end

    // CPU read mux; unmapped indices return zero.
    always_comb begin
        read_byte = '0;
        case (address)
            ADDR_ENABLE:  read_byte = enable_byte;
            ADDR_LEVEL:   read_byte = 8'(level);
            ADDR_CAUSE:   read_byte = cause_byte;
            ADDR_PENDING: read_byte = pending_byte;
            default:      read_byte = '0;
        endcase
    end

    mux_rr_picker #(
        .WIDTH (NUM_SOURCES),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (eligible),
        .start (start_idx),
        .found (pick_found),
        .index (pick_index)
    );

    // FSM state register.
    always_ff @(posedge cpu_clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // FSM next-state, control strobes and interrupt outputs.
    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        set_valid  = 1'b0;
        clr_valid  = 1'b0;
        int_reqn   = 1'b1;
        irq_number = '0;
        case (state)
            ST_IDLE: begin
                if (|eligible) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                // Eligibility may vanish between IDLE and SCAN; fall back if so.
                if (pick_found) begin
                    load_grant = 1'b1;
                    state_next = ST_REQUEST;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                int_reqn   = 1'b0;
                irq_number = level;
                // Losing eligibility beats a coincident acknowledge.
                if (!eligible[grant]) begin
                    state_next = ST_IDLE;
                end else if (int_ack) begin
                    set_valid  = 1'b1;
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (cause_hit || granted_w1c) begin
                    clr_valid  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (wr_clear_all) state_next = ST_IDLE;
    end

    // Edge history, CPU-visible registers, grant bookkeeping and read data.
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            src_prev   <= '0;
            pending    <= '0;
            enable     <= '0;
            level      <= LEVEL_WIDTH'(LEVEL_RESET);
            global_en  <= 1'b0;
            valid      <= 1'b0;
            grant      <= '0;
            last_grant <= LAST_IDX;
            data_out   <= '0;
        end else begin
            src_prev <= src_level;
            if (wr_clear_all) begin
                // New edges still land so no event is lost across a clear-all.
                pending   <= rise;
                enable    <= '0;
                level     <= LEVEL_WIDTH'(LEVEL_RESET);
                global_en <= 1'b0;
                valid     <= 1'b0;
            end else begin
                // Set wins over a same-cycle clear.
                pending <= (pending & ~clear_vec) | rise;
                if (wr_enable)          enable    <= wr_vec;
                if (wr_level)           level     <= data_in[LEVEL_WIDTH-1:0];
                if (wr_global_off)      global_en <= 1'b0;
                else if (wr_global_on)  global_en <= 1'b1;
                if (set_valid)          valid     <= 1'b1;
                else if (clr_valid)     valid     <= 1'b0;
            end
            if (load_grant) begin
                grant      <= pick_index;
                last_grant <= pick_index;
            end
            if (cpu_read) data_out <= read_byte;
        end
    end

endmodule

// File: tb/tb_mux_int_arbiter.sv
// Self-checking bench for mux_int_arbiter: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_mux_int_arbiter;
    import mux_pkg::*;

    localparam int NCH  = 4;
    localparam int NSRC = 2 * NCH;
    localparam int M_IDLE = 0, M_SCAN = 1, M_REQ = 2, M_SERV = 3;

    // ---------------- clock / reset / DUT ----------------
    logic            cpu_clock = 1'b0;
    logic            reset;
    logic [NCH-1:0]  rx_ready, tx_idle;
    logic            selected, write_en, int_ack;
    logic [4:0]      address;
    logic [7:0]      data_in, data_out;
    logic            int_reqn;
    logic [3:0]      irq_number;
    mux_state_e      fsm_state;

    always #5 cpu_clock = ~cpu_clock;

    mux_int_arbiter #(.NUM_CHANNELS(NCH), .LEVEL_WIDTH(4)) dut (
        .cpu_clock  (cpu_clock),
        .reset      (reset),
        .rx_ready   (rx_ready),
        .tx_idle    (tx_idle),
        .selected   (selected),
        .address    (address),
        .write_en   (write_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .int_ack    (int_ack),
        .int_reqn   (int_reqn),
        .irq_number (irq_number),
        .fsm_state  (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Enable/pending kept in the CPU byte layout; sources addressed by k = 2*ch + type.
    logic [7:0] m_pend, m_en, m_dout;
    logic [3:0] m_level, m_prev_rx, m_prev_tx;
    bit         m_gen, m_valid;
    int         m_mode, m_grant, m_last;

    function automatic int bp(input int k);
        return (k % 2) * 4 + k / 2;
    endfunction

    function automatic bit elig(input int k);
        return m_pend[bp(k)] && m_en[bp(k)] && m_gen;
    endfunction

    function automatic logic [7:0] cause_of(input int k);
        return 8'h80 | 8'((k % 2) * 4) | 8'(k / 2);
    endfunction

    task automatic model_reset();
        m_pend = 0; m_en = 0; m_dout = 0; m_level = 0;
        m_prev_rx = 0; m_prev_tx = 0;
        m_gen = 0; m_valid = 0;
        m_mode = M_IDLE; m_grant = 0; m_last = NSRC - 1;
    endtask

    task automatic model_clock();
        bit rd, wr, cause_hit, found;
        logic [7:0] n_pend, n_en, n_dout;
        logic [3:0] n_level;
        bit n_gen, n_valid;
        int n_mode, n_grant, n_last, k;
        rd = selected && !write_en;
        wr = selected && write_en;
        n_pend = m_pend; n_en = m_en; n_dout = m_dout; n_level = m_level;
        n_gen = m_gen; n_valid = m_valid;
        n_mode = m_mode; n_grant = m_grant; n_last = m_last;
        cause_hit = rd && address == 5'd2 && m_valid;
        if (rd) begin
            case (address)
                5'd0:    n_dout = m_en;
                5'd1:    n_dout = {4'h0, m_level};
                5'd2:    n_dout = m_valid ? cause_of(m_grant) : 8'h00;
                5'd3:    n_dout = m_pend;
                default: n_dout = 8'h00;
            endcase
        end
        case (m_mode)
            M_IDLE: if (m_gen && (m_pend & m_en) != 0) n_mode = M_SCAN;
            M_SCAN: begin
                found = 0;
                for (int off = 1; off <= NSRC; off++) begin
                    k = (m_last + off) % NSRC;
                    if (!found && elig(k)) begin
                        found = 1; n_grant = k; n_last = k;
                    end
                end
                n_mode = found ? M_REQ : M_IDLE;
            end
            M_REQ: begin
                if (!elig(m_grant)) n_mode = M_IDLE;
                else if (int_ack) begin n_valid = 1; n_mode = M_SERV; end
            end
            default: begin
                if (cause_hit || (wr && address == 5'd3 && data_in[bp(m_grant)])) begin
                    n_valid = 0; n_mode = M_IDLE;
                end
            end
        endcase
        if (cause_hit) n_pend[bp(m_grant)] = 1'b0;
        if (wr) begin
            case (address)
                5'd0:  n_en = data_in;
                5'd1:  n_level = data_in[3:0];
                5'd3:  n_pend = n_pend & ~data_in;
                5'd13: n_gen = 0;
                5'd14: n_gen = 1;
                5'd15: begin
                    n_en = 0; n_level = 0; n_pend = 0; n_valid = 0; n_gen = 0; n_mode = M_IDLE;
                end
                default: ;
            endcase
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (rx_ready[ch] && !m_prev_rx[ch]) n_pend[ch] = 1'b1;
            if (tx_idle[ch] && !m_prev_tx[ch])  n_pend[4+ch] = 1'b1;
        end
        m_prev_rx = rx_ready; m_prev_tx = tx_idle;
        m_pend = n_pend; m_en = n_en; m_dout = n_dout; m_level = n_level;
        m_gen = n_gen; m_valid = n_valid;
        m_mode = n_mode; m_grant = n_grant; m_last = n_last;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge cpu_clock);
        if (reset) model_reset();
        else       model_clock();
        #1;
        check("int_reqn", int_reqn, m_mode != M_REQ);
        if (m_mode == M_REQ) check("irq_number", irq_number, m_level);
        check("data_out", data_out, m_dout);
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
        selected = 1; write_en = 1; address = a; data_in = d;
        cycle();
        selected = 0; write_en = 0;
    endtask

    task automatic cpu_read(input logic [4:0] a);
        selected = 1; write_en = 0; address = a;
        cycle();
        selected = 0;
    endtask

    task automatic pulse_rx(input int ch);
        rx_ready[ch] = 1'b1;
        cycle();
        rx_ready[ch] = 1'b0;
    endtask

    // Wait (bounded) for the request, acknowledge it, and read the cause.
    task automatic serve(input string tag);
        int n = 0;
        logic [7:0] exp;
        while (int_reqn && n < 12) begin
            cycle();
            n++;
        end
        check({tag, "_req"}, int_reqn, 1'b0);
        int_ack = 1;
        cycle();
        int_ack = 0;
        check({tag, "_ack"}, int_reqn, 1'b1);
        cpu_read(5'd2);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_cause"}, data_out, exp);
    endtask

    logic [4:0] addr_tab[14] = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3,
                                 5'd13, 5'd14, 5'd14, 5'd14, 5'd15, 5'd5, 5'd20};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1; rx_ready = 0; tx_idle = 0; selected = 0; write_en = 0;
        int_ack = 0; address = 0; data_in = 0;
        cycle();
        cycle();
        reset = 0;
        check("rst_int_reqn", int_reqn, 1'b1);
        check("rst_irq", irq_number, 4'h0);
        check("rst_dout", data_out, 8'h00);

        // Basic request / acknowledge / cause read.
        cpu_write(5'd0, 8'h01);
        cpu_write(5'd1, 8'h05);
        cpu_write(5'd14, 8'h00);
        pulse_rx(0);
        cycle();
        check("t1_not_yet", int_reqn, 1'b1);
        cycle();
        check("t1_reqn", int_reqn, 1'b0);
        check("t1_irq", irq_number, 4'h5);
        exp_q.push_back(8'h80);
        serve("t1");
        cpu_read(5'd3);
        check("t1_pending", data_out, 8'h00);
        check("t1_idle", int_reqn, 1'b1);

        // Round-robin over three simultaneous sources.
        cpu_write(5'd0, 8'hFF);
        rx_ready[1] = 1; rx_ready[2] = 1; tx_idle[0] = 1;
        cycle();
        rx_ready = 0; tx_idle = 0;
        exp_q.push_back(8'h84);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h82);
        serve("t2a");
        serve("t2b");
        serve("t2c");

        // Masked source stays pending until enabled.
        cpu_write(5'd0, 8'hF7);
        pulse_rx(3);
        repeat (4) cycle();
        check("t3_masked", int_reqn, 1'b1);
        cpu_read(5'd3);
        check("t3_pending", data_out, 8'h08);
        cpu_write(5'd0, 8'hFF);
        cycle();
        check("t3_scan", int_reqn, 1'b1);
        cycle();
        check("t3_req", int_reqn, 1'b0);
        exp_q.push_back(8'h83);
        serve("t3");

        // Global disable drops an outstanding request.
        pulse_rx(0);
        cycle();
        cycle();
        check("t4_req", int_reqn, 1'b0);
        cpu_write(5'd13, 8'h00);
        cycle();
        check("t4_drop", int_reqn, 1'b1);
        cpu_read(5'd3);
        check("t4_pending", data_out, 8'h01);
        cpu_read(5'd2);
        check("t4_cause", data_out, 8'h00);
        cpu_write(5'd14, 8'h00);
        exp_q.push_back(8'h80);
        serve("t4");

        // Same-cycle set and clear on the granted bit.
        pulse_rx(0);
        cycle();
        cycle();
        check("t5_req", int_reqn, 1'b0);
        rx_ready[0] = 1;
        cpu_write(5'd3, 8'h01);
        rx_ready[0] = 0;
        cycle();
        cycle();
        check("t5_hold", int_reqn, 1'b0);
        cpu_read(5'd3);
        check("t5_pending", data_out, 8'h01);
        exp_q.push_back(8'h80);
        serve("t5");

        // Reset while in SERVICE.
        pulse_rx(0);
        cycle();
        cycle();
        int_ack = 1;
        cycle();
        int_ack = 0;
        check("t6_service", int_reqn, 1'b1);
        reset = 1;
        cycle();
        reset = 0;
        check("t6_reqn", int_reqn, 1'b1);
        check("t6_irq", irq_number, 4'h0);
        check("t6_dout", data_out, 8'h00);
        cpu_read(5'd2);
        check("t6_cause", data_out, 8'h00);
        cpu_read(5'd0);
        check("t6_enable", data_out, 8'h00);

        // Randomized traffic against the model.
        cpu_write(5'd0, 8'hFF);
        cpu_write(5'd1, 8'h09);
        cpu_write(5'd14, 8'h00);
        for (int i = 0; i < 2000; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 7) == 0) rx_ready[ch] = ~rx_ready[ch];
                if ($urandom_range(0, 7) == 0) tx_idle[ch]  = ~tx_idle[ch];
            end
            int_ack  = ($urandom_range(0, 3) == 0);
            selected = ($urandom_range(0, 2) == 0);
            write_en = 1'($urandom_range(0, 1));
            address  = addr_tab[$urandom_range(0, 13)];
            data_in  = 8'($urandom_range(0, 255));
            reset    = ($urandom_range(0, 499) == 0);
            cycle();
        end
        selected = 0; write_en = 0; int_ack = 0; reset = 0;
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
